alu_exec_sequencer: RTL and testbench

//  EX-stage sequencer wrapped around the ALU operation encoding (and=0000, or=0001, add=0010, sub=0110,
//  slt=0111, mul=1000). Single-cycle ops complete in 1 cycle; mul runs an iterative shift-add over WIDTH

---
 rtl/alu_exec_sequencer.sv | 115 +++++++++++
 tb/tb_alu_exec_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// EX-stage sequencer: single-cycle ALU ops plus an iterative shift-add multiplier,
// with valid/ready handshakes on both sides and a stall output for hazard logic.
module alu_exec_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             stall
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] alu_res;
    logic             legal;
    logic             accept;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = (state == MUL) || (out_valid && !out_ready) || (in_valid && !in_ready);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (alu_ctrl)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_MUL:  alu_res = '0;
            default: legal   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            // Retirement first; a same-cycle accept below overrides these defaults.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                zero      <= 1'b0;
                illegal   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_ctrl == OP_MUL) begin
                            mcand  <= src_a;
                            mplier <= src_b;
                            acc    <= '0;
                            count  <= '0;
                            state  <= MUL;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= !legal;
                        end
                    end
                end
                MUL: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    acc    <= acc_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        illegal   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer: table of single-cycle ops plus
// hand-written multiply, backpressure, streaming and reset-abort sequences.
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int bad;
        in_valid  = 1'b1;
        alu_ctrl  = 4'b1000;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        #1;
        check("mul_in_ready_at_accept", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!(stall === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) bad++;
            step();
        end
        check("mul_stall_window_bad_cycles", bad, 0);
        check("mul_out_valid", {31'b0, out_valid}, 32'd1);
        check("mul_result", result, exp);
        check("mul_zero", {31'b0, zero}, {31'b0, (exp == 32'd0)});
        check("mul_illegal", {31'b0, illegal}, 32'd0);
        step();
        check("mul_retired", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int bad;

        vecs[0] = '{4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{4'b0110, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0};
        vecs[2] = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[3] = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[4] = '{4'b0000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0};
        vecs[5] = '{4'b0001, 32'h0000_F0F0,  32'h0F00_FF00,  32'h0F00_FFF0,  1'b0, 1'b0};
        vecs[6] = '{4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[7] = '{4'b1111, 32'd9,          32'd9,          32'd0,          1'b1, 1'b1};
        vecs[8] = '{4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[9] = '{4'b0111, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = 4'b0000;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);

        // Table of single-cycle ops: latency 1, then retire.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            alu_ctrl = vecs[i].ctrl;
            src_a    = vecs[i].a;
            src_b    = vecs[i].b;
            #1;
            check("tbl_in_ready", {31'b0, in_ready}, 32'd1);
            check("tbl_stall_offer", {31'b0, stall}, 32'd0);
            step();
            in_valid = 1'b0;
            check("tbl_out_valid", {31'b0, out_valid}, 32'd1);
            check("tbl_result", result, vecs[i].exp_res);
            check("tbl_zero", {31'b0, zero}, {31'b0, vecs[i].exp_zero});
            check("tbl_illegal", {31'b0, illegal}, {31'b0, vecs[i].exp_ill});
            check("tbl_stall", {31'b0, stall}, 32'd0);
            step();
            check("tbl_retired", {31'b0, out_valid}, 32'd0);
            check("tbl_illegal_cleared", {31'b0, illegal}, 32'd0);
        end

        do_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        do_mul(32'h0001_0000, 32'h0001_0000, 32'd0);
        do_mul(32'd6, 32'd7, 32'd42);
        do_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);

        // Backpressure: add 1+1 held for 3 cycles with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_ctrl  = 4'b0010;
        src_a     = 32'd1;
        src_b     = 32'd1;
        step();
        alu_ctrl  = 4'b0000;
        src_a     = 32'd3;
        src_b     = 32'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, 32'd2);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_stall", {31'b0, stall}, 32'd1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_retired", {31'b0, out_valid}, 32'd0);
        check("bp_no_phantom_accept", result, 32'd2);

        // Back-to-back adds: one result per cycle.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_ctrl = 4'b0010;
            src_a    = 32'(i + 10);
            src_b    = 32'd100;
            step();
            #1;
            check("stream_out_valid", {31'b0, out_valid}, 32'd1);
            check("stream_result", result, 32'(i + 110));
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        // Reset during MUL cycle 10 aborts the multiply.
        in_valid = 1'b1;
        alu_ctrl = 4'b1000;
        src_a    = 32'd3;
        src_b    = 32'd3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("abort_pre_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_result", result, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        check("abort_no_late_result", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
